if_fetch_stage: RTL

Instruction-fetch responder for the pipelined MIPS data path: accepts the program counter and IM read enable from the PC unit, reads the addressed word from an on-chip instruction memory, and presents it in the IF/ID pipeline register. Honours the same branch-flush and load-stall controls the PC unit sees, so PC and IR stay paired. Flags misaligned or out-of-range fetch addresses. Provides a word-write load port used at boot or by the bench.

---
 rtl/if_pkg.sv | 28 ++
 rtl/imem_array.sv | 27 ++
 rtl/if_fetch_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // Wrap-around offset from the memory base, expressed in words.
  function automatic logic [31:0] word_index(input logic [31:0] pc,
                                             input logic [31:0] base);
    logic [31:0] diff;
    diff = pc - base;
    return diff >> 2;
  endfunction

  function automatic logic fetch_bad(input logic [31:0] pc,
                                     input logic [31:0] base,
                                     input logic [31:0] depth);
    return (pc[1:0] != 2'b00) || (pc < base) || (word_index(pc, base) >= depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage with a read-first synchronous read port
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH];

  // Storage is deliberately unreset so boot loads can proceed while rstn is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - fetch responder: address check, IF/ID register, fault capture
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   pc,
  input  logic          im_read_en,
  input  logic          br_flag,
  input  logic          load_stop_request,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   if_id_ir,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_pc4,
  output logic          if_id_valid,
  output logic          addr_fault,
  output logic [31:0]   fault_pc
);

  logic [31:0] idx;
  logic        bad;
  logic        fetch_ok;
  logic [31:0] rd_data;

  logic [31:0] pc_q,  pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fpc_q,   fpc_d;

  ifid_t ifid;

  assign idx = word_index(pc, BASE_ADDR);
  assign bad = fetch_bad(pc, BASE_ADDR, 32'(DEPTH));

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk     (clk),
    .rd_en   (fetch_ok),
    .rd_addr (idx[AW-1:0]),
    .rd_data (rd_data),
    .wr_en   (load_we),
    .wr_addr (load_addr),
    .wr_data (load_data)
  );

  // Flush beats stall beats idle beats bad address; only a clean fetch reads memory.
  always_comb begin
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    fetch_ok = 1'b0;
    if (br_flag) begin
      valid_d = 1'b0;
    end else if (load_stop_request) begin
      valid_d = valid_q;
    end else if (!im_read_en) begin
      valid_d = 1'b0;
    end else if (bad) begin
      valid_d = 1'b0;
      pc_d    = pc;
    end else begin
      fetch_ok = 1'b1;
      valid_d  = 1'b1;
      pc_d     = pc;
      pc4_d    = pc + 32'd4;
    end
  end

  always_comb begin
    fault_d = fault_q;
    fpc_d   = fpc_q;
    if (!fault_q && bad && im_read_en && !br_flag && !load_stop_request) begin
      fault_d = 1'b1;
      fpc_d   = pc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= BASE_ADDR;
      pc4_q   <= BASE_ADDR + 32'd4;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      fpc_q   <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  // The memory read register only advances on a clean fetch, so gating it with
  // valid gives the NOP-on-flush and hold-on-stall behaviour without a copy of ir.
  always_comb begin
    ifid.ir    = valid_q ? rd_data : NOP_INSTR;
    ifid.pc    = pc_q;
    ifid.pc4   = pc4_q;
    ifid.valid = valid_q;
  end

  assign if_id_ir    = ifid.ir;
  assign if_id_pc    = ifid.pc;
  assign if_id_pc4   = ifid.pc4;
  assign if_id_valid = ifid.valid;
  assign addr_fault  = fault_q;
  assign fault_pc    = fpc_q;

endmodule
